mmio_uart_tx: RTL and testbench

//   Memory-mapped UART transmitter on the CPU I/O bus, beside the GPIO latch.

---
 rtl/mmio_uart_tx_if.sv | 10 +
 rtl/mmio_uart_tx.sv | 108 ++++++++++
 tb/tb_mmio_uart_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU I/O bus slice seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        io_en;
    logic        sel;
    modport master (output addr, wr_data, io_en, input sel, rd_data);
    modport slave (input addr, wr_data, io_en, output sel, rd_data);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: CPU-bus UART transmitter with TX FIFO, 8N1 serialiser, status register and done irq.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0010,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_tx_if.slave   bus,
    output logic            txd,
    output logic            irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] sh, sh_n;
    logic [1:0] off;
    logic txd_n, ovf, full, empty, wr, push_req, push, pop, last, unused;
    assign off      = bus.addr[3:2];
    assign bus.sel  = bus.addr[31:4] == BASE_ADDR[31:4];
    assign wr       = bus.io_en & bus.sel;
    assign push_req = wr && off == 2'd0;
    assign full     = count == CW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign push     = push_req & ~full;
    assign pop      = state == IDLE && !empty;
    assign last     = baud == BW'(CLKS_PER_BIT - 1);
    assign count_n  = count + CW'(push) - CW'(pop);
    assign bus.rd_data = bus.sel && off == 2'd1 ?
        {16'h0, 8'(count), 4'h0, ovf, state != IDLE, empty, full} : '0;
    assign unused   = ^{bus.wr_data[31:8], bus.addr[1:0]};
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.wr_data[7:0];
    // A full-FIFO push is dropped even when the FSM pops that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq    <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            ovf   <= wr && off == 2'd1 ? 1'b0 : ovf | (push_req & full);
            irq   <= state_n == IDLE && count_n == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            txd     <= txd_n;
        end
    end
    always_comb begin
        state_n = state;
        baud_n  = '0;
        bit_n   = bit_idx;
        sh_n    = sh;
        txd_n   = txd;
        case (state)
            IDLE:
                if (pop) begin
                    state_n = START;
                    sh_n    = mem[rd_ptr];
                    txd_n   = 1'b0;
                end
            START:
                if (last) begin
                    state_n = DATA;
                    bit_n   = '0;
                    txd_n   = sh[0];
                end else baud_n = baud + 1'b1;
            DATA:
                if (last) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                        sh_n  = sh >> 1;
                        txd_n = sh[1];
                    end
                end else baud_n = baud + 1'b1;
            STOP:
                if (last) state_n = IDLE;
                else baud_n = baud + 1'b1;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized bench with a UART receiver model and byte scoreboard for mmio_uart_tx.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0010;
    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB + 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, irq;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int fall_q[$];
    mmio_uart_tx_if bus ();
    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .txd(txd), .irq(irq)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end
    // Receiver model: mid-bit sampling of each frame; frames cut by reset are discarded.
    initial begin
        logic [9:0] f;
        int t;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || txd !== 1'b0) continue;
            t  = cyc;
            ab = 1'b0;
            for (int j = 0; j < 10; j++) begin
                repeat (j == 0 ? CPB / 2 : CPB) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                f[j] = txd;
            end
            if (!ab) begin
                checks++;
                if (f[0] !== 1'b0 || f[9] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_format: start=%b stop=%b, required start=0 stop=1", f[0], f[9]);
                end
                rx_q.push_back(f[8:1]);
                fall_q.push_back(t);
            end
        end
    end
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.io_en   = 1'b1;
    endtask
    task automatic bus_idle();
        @(negedge clk);
        bus.io_en = 1'b0;
    endtask
    task automatic push(input logic [7:0] d);
        bus_write(BASE, {$urandom_range(0, 255), 16'h0, d});
    endtask
    task automatic read_status(output logic [31:0] v);
        bus.addr = BASE + 32'd4;
        #1 v = bus.rd_data;
    endtask
    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: irq=%b after %0d cycles, required 1", name, irq, n);
        end
    endtask
    task automatic compare_rx(input string name);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: received %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h, required %h", name, i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        fall_q.delete();
    endtask
    task automatic wait_fall(input string name);
        int n = 0;
        while (txd !== 1'b0 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: txd=%b, required 0 within 4 cycles", name, txd);
        end
    endtask
    task automatic test_reset();
        logic [31:0] v;
        int bad = 0;
        bus.io_en   = 1'b0;
        bus.addr    = 32'h0;
        bus.wr_data = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: txd=%b irq=%b, required 1 1", txd, irq);
        end
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle_txd: %0d low cycles, required 0", bad);
        end
        read_status(v);
        checks++;
        if (v !== 32'h0000_0002 || irq !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: status=%h irq=%b, required 00000002 1", v, irq);
        end
    endtask
    task automatic test_frame_a5();
        logic [7:0] b = 8'hA5;
        int bad = 0;
        logic e;
        push(b);
        exp_q.push_back(b);
        bus_idle();
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL a5_no_bypass: txd=%b right after write, required 1", txd);
        end
        wait_fall("a5");
        for (int i = 0; i < 10 * CPB; i++) begin
            e = i < CPB ? 1'b0 : i < 9 * CPB ? b[i / CPB - 1] : 1'b1;
            if (txd !== e) bad++;
            if (i == 5 * CPB && irq !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL a5_waveform: %0d wrong cycles, required 0", bad);
        end
        checks++;
        if (txd !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL a5_after_frame: txd=%b irq=%b, required 1 1", txd, irq);
        end
        compare_rx("a5");
    endtask
    task automatic test_overflow();
        logic [31:0] v;
        logic [7:0] d;
        for (int k = 0; k < 9; k++) begin
            d = 8'($urandom);
            push(d);
            exp_q.push_back(d);
        end
        bus_idle();
        read_status(v);
        checks++;
        if (v !== 32'h0000_0805) begin
            errors++;
            $display("FAIL ovf_full_status: status=%h, required 00000805", v);
        end
        push(8'($urandom));
        bus_idle();
        read_status(v);
        checks++;
        if (v !== 32'h0000_080D) begin
            errors++;
            $display("FAIL ovf_set_status: status=%h, required 0000080d", v);
        end
        bus_write(BASE + 32'd4, $urandom);
        bus_idle();
        read_status(v);
        checks++;
        if (v !== 32'h0000_0805) begin
            errors++;
            $display("FAIL ovf_clear_status: status=%h, required 00000805", v);
        end
        wait_done(9 * FRAME + 100, "ovf");
        for (int i = 1; i < fall_q.size(); i++) begin
            checks++;
            if (fall_q[i] - fall_q[i-1] != FRAME) begin
                errors++;
                $display("FAIL ovf_spacing%0d: %0d cycles, required %0d", i, fall_q[i] - fall_q[i-1], FRAME);
            end
        end
        compare_rx("ovf");
    endtask
    task automatic test_full_pop();
        logic [31:0] v;
        logic [7:0] d;
        int n = 0;
        for (int k = 0; k < 9; k++) begin
            d = 8'($urandom);
            push(d);
            exp_q.push_back(d);
        end
        bus_idle();
        read_status(v);
        while (!(v[2] == 1'b0 && v[15:8] == 8'd8) && n < 2 * FRAME) begin
            @(negedge clk);
            read_status(v);
            n++;
        end
        checks++;
        if (v[2] !== 1'b0 || v[15:8] !== 8'd8) begin
            errors++;
            $display("FAIL fullpop_wait: status=%h, required idle with count 8", v);
        end
        bus.addr    = BASE;
        bus.wr_data = $urandom;
        bus.io_en   = 1'b1;
        bus_idle();
        read_status(v);
        checks++;
        if (v !== 32'h0000_070C) begin
            errors++;
            $display("FAIL fullpop_status: status=%h, required 0000070c", v);
        end
        bus_write(BASE + 32'd4, 32'h0);
        bus_idle();
        wait_done(9 * FRAME + 100, "fullpop");
        compare_rx("fullpop");
    endtask
    task automatic test_reset_mid();
        logic [31:0] v;
        int bad = 0;
        for (int k = 0; k < 3; k++) push(8'($urandom));
        bus_idle();
        wait_fall("rstmid");
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        read_status(v);
        checks++;
        if (txd !== 1'b1 || v !== 32'h0000_0002 || irq !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: txd=%b status=%h irq=%b, required 1 00000002 1", txd, v, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: %0d low cycles after reset, required 0", bad);
        end
        compare_rx("rstmid");
    endtask
    task automatic test_unmapped();
        logic [31:0] v;
        bus_write(BASE + 32'd8, $urandom);
        bus_write(BASE + 32'd12, $urandom);
        bus_write(32'h0000_0010, $urandom);
        bus_write(32'h1234_5670, $urandom);
        bus_idle();
        read_status(v);
        checks++;
        if (v !== 32'h0000_0002) begin
            errors++;
            $display("FAIL unmapped_status: status=%h, required 00000002", v);
        end
        bus.addr = BASE + 32'd8;
        #1;
        checks++;
        if (bus.rd_data !== 32'h0 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_rd2: rd=%h sel=%b, required 0 1", bus.rd_data, bus.sel);
        end
        bus.addr = BASE + 32'd12;
        #1;
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_rd3: rd=%h, required 0", bus.rd_data);
        end
        bus.addr = BASE;
        #1;
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: rd=%h, required 0", bus.rd_data);
        end
        bus.addr = 32'h0000_0014;
        #1;
        checks++;
        if (bus.rd_data !== 32'h0 || bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL unsel_read: rd=%h sel=%b, required 0 0", bus.rd_data, bus.sel);
        end
        repeat (2 * FRAME) @(negedge clk);
        compare_rx("unmapped");
    endtask
    task automatic test_random();
        logic [31:0] v;
        logic [7:0] d;
        int gap;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) begin
                d = 8'($urandom);
                push(d);
                exp_q.push_back(d);
                gap = $urandom_range(0, 40);
                if (gap > 0) begin
                    bus_idle();
                    repeat (gap - 1) @(negedge clk);
                end
            end
            bus_idle();
            wait_done(6 * FRAME + 200, "random");
            read_status(v);
            checks++;
            if (v !== 32'h0000_0002) begin
                errors++;
                $display("FAIL random_status%0d: status=%h, required 00000002", r, v);
            end
            compare_rx("random");
        end
    endtask
    initial begin
        test_reset();
        test_frame_a5();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_unmapped();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
